// File: rtl/sm_mem_pkg.sv
// Shared types and default parameter values for the SM data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sm_mem_pkg;

    localparam int DEF_N_CORES        = 4;
    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_ADDR_WIDTH     = 16;
    localparam int DEF_MEM_ADDR_WIDTH = 8;
    localparam int DEF_LATENCY        = 2;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } mem_state_e;

endpackage

// File: rtl/sm_mem_ram.sv
// Single-port word RAM, no reset on contents.
// Latency: write commits on the rising edge; read is combinational.
// Backpressure: none, one access per cycle.
//
// Ports:
//   clk     - clock
//   we_i    - write enable for this cycle
//   addr_i  - word index shared by read and write
//   wdata_i - write data
//   rdata_o - asynchronous read data at addr_i
module sm_mem_ram
    import sm_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      we_i,
    input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic [DATA_WIDTH-1:0]     rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**MEM_ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sm_data_mem.sv
// Data-memory responder: serialises enabled lane loads/stores through one RAM port.
// Latency: MReady in cycle N_CORES+LATENCY+1 after the request is seen in IDLE.
// Backpressure: MRead/MWrite are levels held until MReady; one transaction at a time.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   MRead, MWrite   - load / store request levels from the scheduler
//   MReady          - registered one-cycle completion pulse
//   en_mask         - per-lane enables, latched at acceptance
//   addr, wdata     - packed per-lane address / store data, lane i at [i*W +: W]
//   rdata           - registered per-lane load data
//   err             - sticky flag: MRead and MWrite both high at acceptance
module sm_data_mem
    import sm_mem_pkg::*;
#(
    parameter int N_CORES        = DEF_N_CORES,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int LATENCY        = DEF_LATENCY
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             MRead,
    input  logic                             MWrite,
    output logic                             MReady,
    input  logic [N_CORES-1:0]               en_mask,
    input  logic [N_CORES*ADDR_WIDTH-1:0]    addr,
    input  logic [N_CORES*DATA_WIDTH-1:0]    wdata,
    output logic [N_CORES*DATA_WIDTH-1:0]    rdata,
    output logic                             err
);

    localparam int LANE_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int WAIT_W    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int LAST_LANE = N_CORES - 1;

    mem_state_e                          state_q, state_d;
    logic [LANE_W-1:0]                   lane_q, lane_d;
    logic [WAIT_W-1:0]                   wait_q, wait_d;
    logic [N_CORES-1:0]                  en_q, en_d;
    logic [N_CORES*ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [N_CORES*DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic                                wr_q, wr_d;
    logic [N_CORES*DATA_WIDTH-1:0]       rdata_q, rdata_d;
    logic                                err_q, err_d;
    logic                                mready_q, mready_d;

    logic                                lane_en;
    logic                                ram_we;
    logic [MEM_ADDR_WIDTH-1:0]           ram_addr;
    logic [DATA_WIDTH-1:0]               ram_wdata;
    logic [DATA_WIDTH-1:0]               ram_rdata;

    // Upper address bits are deliberately dropped so addresses wrap modulo depth.
    logic addr_hi_unused;
    assign addr_hi_unused = ^addr_q;

    // Lane mux: select the current lane's latched address/data.
    always_comb begin
        ram_addr  = addr_q[int'(lane_q)*ADDR_WIDTH +: MEM_ADDR_WIDTH];
        ram_wdata = wdata_q[int'(lane_q)*DATA_WIDTH +: DATA_WIDTH];
        lane_en   = en_q[lane_q];
        // Gating with reset keeps a lane from committing in the aborting cycle.
        ram_we    = (state_q == ACCESS) && lane_en && wr_q && !reset;
    end

    sm_mem_ram #(
        .DATA_WIDTH     (DATA_WIDTH),
        .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        wait_d   = wait_q;
        en_d     = en_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (MRead || MWrite) begin
                    en_d    = en_mask;
                    addr_d  = addr;
                    wdata_d = wdata;
                    // A conflicting request is treated as a read.
                    wr_d    = MWrite && !MRead;
                    if (MRead && MWrite) begin
                        err_d = 1'b1;
                    end
                    lane_d  = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (lane_en && !wr_q) begin
                    rdata_d[int'(lane_q)*DATA_WIDTH +: DATA_WIDTH] = ram_rdata;
                end
                if (lane_q == LANE_W'(LAST_LANE)) begin
                    lane_d = '0;
                    if (LATENCY > 0) begin
                        wait_d  = WAIT_W'(LATENCY);
                        state_d = WAIT;
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            WAIT: begin
                if (wait_q == WAIT_W'(1)) begin
                    wait_d  = '0;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered pulse: high exactly while the FSM sits in RESP.
        mready_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lane_q   <= '0;
            wait_q   <= '0;
            en_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            mready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            wait_q   <= wait_d;
            en_q     <= en_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            mready_q <= mready_d;
        end
    end

    assign MReady = mready_q;
    assign rdata  = rdata_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sm_data_mem.sv
module tb_sm_data_mem;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int MAW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 MRead, MWrite, MReady, err;
    logic [N-1:0]         en_mask;
    logic [N-1:0][AW-1:0] addr;
    logic [N-1:0][DW-1:0] wdata;
    logic [N*DW-1:0]      rdata;

    // Second instance with LATENCY=0 for back-to-back timing.
    logic                 mread0, mwrite0, mready0, err0;
    logic [N-1:0]         mask0;
    logic [N-1:0][AW-1:0] addr0;
    logic [N-1:0][DW-1:0] wdata0;
    logic [N*DW-1:0]      rdata0;

    sm_data_mem #(.N_CORES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                  .MEM_ADDR_WIDTH(MAW), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .MRead(MRead), .MWrite(MWrite), .MReady(MReady),
        .en_mask(en_mask), .addr(addr), .wdata(wdata), .rdata(rdata), .err(err));

    sm_data_mem #(.N_CORES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                  .MEM_ADDR_WIDTH(MAW), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .MRead(mread0), .MWrite(mwrite0), .MReady(mready0),
        .en_mask(mask0), .addr(addr0), .wdata(wdata0), .rdata(rdata0), .err(err0));

    // Reference model: the RAM as a plain array, lane load results, sticky error.
    logic [DW-1:0]        mem_m [256];
    logic [N-1:0][DW-1:0] rd_m;
    bit                   err_m;
    int                   total = 0;
    int                   bad   = 0;

    typedef struct {
        bit                   rd;
        bit                   wr;
        logic [3:0]           mask;
        logic [3:0][15:0]     a;
        logic [3:0][15:0]     d;
        bit                   chk;
        logic [3:0][15:0]     e;
        bit                   e_err;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mkv(bit rd, bit wr, logic [3:0] mask, logic [63:0] a,
                                 logic [63:0] d, bit chk, logic [63:0] e, bit ee);
        vec_t v;
        v.rd = rd; v.wr = wr; v.mask = mask; v.a = a; v.d = d;
        v.chk = chk; v.e = e; v.e_err = ee;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one transaction from IDLE, update the model, check latency, data, pulse width.
    task automatic run_txn(input bit rd, input bit wr, input logic [3:0] mask,
                           input logic [3:0][15:0] a, input logic [3:0][15:0] d,
                           input bit chk, input logic [3:0][15:0] e, input bit ee,
                           input string name);
        int cyc;
        if (rd && wr) err_m = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                if (wr && !rd) mem_m[a[i] % 256] = d[i];
                else           rd_m[i] = mem_m[a[i] % 256];
            end
        end
        MRead = rd; MWrite = wr; en_mask = mask; addr = a; wdata = d;
        cyc = 0;
        while (cyc < 40) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                // Inputs are don't-care after acceptance: scramble them.
                MRead = 1'b0; MWrite = 1'b0; en_mask = 4'($urandom);
                addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
            end
            if (MReady) break;
        end
        check({name, "_latency"}, 64'(cyc), 64'd7);
        check({name, "_rdata"}, rdata, rd_m);
        check({name, "_err"}, 64'(err), 64'(err_m));
        if (chk) begin
            check({name, "_rdata_tbl"}, rdata, e);
            check({name, "_err_tbl"}, 64'(err), 64'(ee));
        end
        tick();
        check({name, "_pulse_width"}, 64'(MReady), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][15:0] a, d;
        int pulses;
        int r;
        bit rd, wr;

        vecs[0]  = mkv(0, 1, 4'hF, {16'h0003, 16'h0002, 16'h0001, 16'h0000},
                       {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 0, 64'h0, 0);
        vecs[1]  = mkv(1, 0, 4'hF, {16'h0000, 16'h0001, 16'h0002, 16'h0003}, 64'h0, 1,
                       {16'h1111, 16'h2222, 16'h3333, 16'h4444}, 0);
        vecs[2]  = mkv(0, 1, 4'hF, {16'h0023, 16'h0022, 16'h0021, 16'h0020},
                       {4{16'hAAAA}}, 0, 64'h0, 0);
        vecs[3]  = mkv(1, 0, 4'hF, {16'h0023, 16'h0022, 16'h0021, 16'h0020}, 64'h0, 1,
                       {4{16'hAAAA}}, 0);
        vecs[4]  = mkv(1, 0, 4'b0101, {16'h0003, 16'h0002, 16'h0001, 16'h0000}, 64'h0, 1,
                       {16'hAAAA, 16'h3333, 16'hAAAA, 16'h1111}, 0);
        vecs[5]  = mkv(0, 1, 4'hF, {16'hFF05, 16'h0205, 16'h0105, 16'h0005},
                       {16'hA004, 16'hA003, 16'hA002, 16'hA001}, 0, 64'h0, 0);
        vecs[6]  = mkv(1, 0, 4'hF, {16'h0005, 16'h0005, 16'h0005, 16'h0105}, 64'h0, 1,
                       {4{16'hA004}}, 0);
        vecs[7]  = mkv(0, 1, 4'h0, {16'h0003, 16'h0002, 16'h0001, 16'h0000},
                       {4{16'hDEAD}}, 1, {4{16'hA004}}, 0);
        vecs[8]  = mkv(1, 0, 4'hF, {16'h0003, 16'h0002, 16'h0001, 16'h0000}, 64'h0, 1,
                       {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 0);
        vecs[9]  = mkv(1, 1, 4'hF, {16'h0000, 16'h0001, 16'h0002, 16'h0003},
                       {4{16'hBEEF}}, 1, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, 1);
        vecs[10] = mkv(1, 0, 4'hF, {16'h0023, 16'h0022, 16'h0021, 16'h0020}, 64'h0, 1,
                       {4{16'hAAAA}}, 1);

        reset = 1'b1; MRead = 0; MWrite = 0; en_mask = '0; addr = '0; wdata = '0;
        mread0 = 0; mwrite0 = 0; mask0 = 4'hF; addr0 = '0; wdata0 = '0;
        rd_m = '0; err_m = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_mready", 64'(MReady), 64'd0);
        check("reset_rdata", rdata, 64'd0);
        check("reset_err", 64'(err), 64'd0);

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].mask, vecs[i].a, vecs[i].d,
                    vecs[i].chk, vecs[i].e, vecs[i].e_err, $sformatf("vec%0d", i));
        end

        // Back-to-back reads with LATENCY=0: pulses in cycles 5, 11, 17.
        mread0 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            check($sformatf("b2b_cyc%0d", c), 64'(mready0),
                  64'((c == 5) || (c == 11) || (c == 17)));
            if (c == 17) mread0 = 1'b0;
        end

        // Reset in cycle 2 of a store: only lane 0 commits.
        run_txn(0, 1, 4'hF, {16'h0043, 16'h0042, 16'h0041, 16'h0040}, {4{16'h0B0B}},
                0, 64'h0, 0, "rst_prep");
        MWrite = 1'b1; en_mask = 4'hF;
        addr  = {16'h0043, 16'h0042, 16'h0041, 16'h0040};
        wdata = {16'h4567, 16'h3456, 16'h2345, 16'h1234};
        tick();
        MWrite = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_m[8'h40] = 16'h1234; rd_m = '0; err_m = 1'b0;
        check("rst_err", 64'(err), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (MReady) pulses++;
            tick();
        end
        check("rst_no_mready", 64'(pulses), 64'd0);
        run_txn(1, 0, 4'hF, {16'h0043, 16'h0042, 16'h0041, 16'h0040}, 64'h0, 1,
                {16'h0B0B, 16'h0B0B, 16'h0B0B, 16'h1234}, 0, "rst_readback");

        // Fill the whole RAM so every later read has a known model value.
        for (int k = 0; k < 64; k++) begin
            for (int i = 0; i < N; i++) begin
                a[i] = 16'(4 * k + i);
                d[i] = 16'($urandom);
            end
            run_txn(0, 1, 4'hF, a, d, 0, 64'h0, 0, $sformatf("fill%0d", k));
        end

        // Randomised traffic against the model; small index range forces collisions.
        for (int k = 0; k < 40; k++) begin
            r  = $urandom_range(0, 9);
            rd = (r < 4) || (r >= 8);
            wr = (r >= 4) && (r <= 8);
            for (int i = 0; i < N; i++) begin
                a[i] = {8'($urandom), 8'($urandom_range(0, 15))};
                d[i] = 16'($urandom);
            end
            run_txn(rd, wr, 4'($urandom), a, d, 0, 64'h0, 0, $sformatf("rand%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sm_data_mem.md
# sm_data_mem

Data-memory responder for one SM core. It sits on the other end of the scheduler's MRead/MWrite/MReady handshake and serves the per-lane load/store requests of all N_CORES lanes. Enabled lanes are serialised through a single-port RAM, and one MReady pulse is returned per transaction. It replaces any zero-latency memory model, so multi-cycle stalls are exercised on the real control path.

## Interface
Parameters:
- N_CORES, 4, number of lanes; must match the scheduler's N_CORES.
- DATA_WIDTH, 16, per-lane word width.
- ADDR_WIDTH, 16, per-lane address width presented by the lanes.
- MEM_ADDR_WIDTH, 8, RAM index width; depth = 2**MEM_ADDR_WIDTH words.
- LATENCY, 2, extra wait cycles after lane access; 0 is legal.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- MRead  in  1  load request, level, held until MReady.
- MWrite  in  1  store request, level, held until MReady.
- MReady  out  1  registered one-cycle completion pulse.
- en_mask  in  N_CORES  lane enables, from the scheduler's PStack.
- addr  in  N_CORES*ADDR_WIDTH  lane i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- wdata  in  N_CORES*DATA_WIDTH  lane store data, same packing.
- rdata  out  N_CORES*DATA_WIDTH  lane load data, registered.
- err  out  1  sticky; set when MRead and MWrite are both high at request acceptance.

## Operation
- FSM states:
  - IDLE: waits for a request.
  - ACCESS: walks the lanes, one per cycle.
  - WAIT: counts down LATENCY cycles.
  - RESP: asserts MReady.
- IDLE: if MRead|MWrite, latch en_mask, addr, wdata, and op into internal registers. Op is write only if MWrite&!MRead. Then go to ACCESS with lane counter 0. Inputs are don't-care after acceptance.
- ACCESS: lane counter i runs 0..N_CORES-1, one lane per cycle, ascending.
  - Disabled lane: no RAM access; its rdata slice is unchanged.
  - Enabled read lane: rdata slice i takes RAM[addr_i[MEM_ADDR_WIDTH-1:0]] at the end of that cycle.
  - Enabled write lane: RAM is written at the end of that cycle.
  - Upper address bits are ignored, so addresses wrap modulo depth.
- Two enabled lanes storing to the same index: the higher lane wins. A read by a later lane sees earlier lanes' writes only across transactions; within one transaction all lanes share the same op.
- After lane N_CORES-1: go to WAIT if LATENCY>0, else RESP.
- WAIT: counter loads LATENCY and decrements; go to RESP when it reaches 1.
- RESP: MReady=1 for exactly this cycle, then IDLE. A request still high in the next cycle is a new transaction; the scheduler has advanced to the next instruction.
- en_mask all zero: full timing is still run, no RAM or rdata change, MReady issued.
- MRead&MWrite together: err is set, a read is performed, and the handshake completes normally. err clears only on reset.

## Timing
- Cycle 0 is the cycle a request is seen in IDLE.
- ACCESS covers cycles 1..N_CORES; WAIT covers N_CORES+1..N_CORES+LATENCY.
- MReady is high in cycle N_CORES+LATENCY+1. Defaults give MReady in cycle 7.
- rdata is final no later than the edge ending cycle N_CORES and is stable while MReady is high. It holds until overwritten by a later enabled read of the same lane.
- Back-to-back requests: the next acceptance is possible in the cycle after RESP, giving a minimum period of N_CORES+LATENCY+2.
- Reset values:
  - state IDLE, MReady 0, rdata 0, err 0, counters 0.
  - RAM contents are not reset.
- Reset mid-transaction: abort immediately, with no MReady. Lane writes already committed stay in RAM; remaining lanes are not written.

## Structure
- Package sm_mem_pkg holds the state enum (IDLE, ACCESS, WAIT, RESP) and the default parameter constants.
- Sub-module sm_mem_ram: single-port RAM with depth 2**MEM_ADDR_WIDTH, DATA_WIDTH wide, synchronous write, asynchronous read, no reset.
- Lane mux, latch registers, FSM, and counters are in sm_data_mem.

## Test plan
- Store then load: en_mask=4'b1111, lanes store 0x1111..0x4444 to addrs 0..3 → MReady in cycle 7 for each transaction. The following load from addrs 3,2,1,0 returns rdata lanes 0x4444,0x3333,0x2222,0x1111.
- Partial mask: preload all rdata slices with 0xAAAA, then load with en_mask=4'b0101 → only lanes 0 and 2 update; lanes 1 and 3 stay 0xAAAA.
- Same-address conflict: all lanes store distinct values to addr 0x05 → a subsequent read returns the lane-3 value. Also, addr 0x0105 aliases 0x05.
- Back-to-back and zero mask: MRead held high across three instructions, LATENCY=0 → MReady pulses every 6 cycles, each one cycle wide. An en_mask=0 store leaves RAM unchanged.
- Error and reset:
  - MRead=MWrite=1 → err=1, read performed, MReady issued.
  - reset asserted in cycle 2 of a store → MReady never pulses, lane 0 written, lanes 1-3 unwritten, err=0 after reset.
